// File: rtl/spifi_line_fill_pkg.sv
// Shared types and encodings for the SPIFI cache line-fill engine.
package spifi_line_fill_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10,
    ST_ERR  = 2'b11
  } state_e;

  // Burst encoding for a line of line_words words, wrapping or incrementing.
  function automatic logic [2:0] burst_enc(input int unsigned line_words, input bit wrap);
    case (line_words)
      32'd8:   return wrap ? HBURST_WRAP8  : HBURST_INCR8;
      32'd16:  return wrap ? HBURST_WRAP16 : HBURST_INCR16;
      default: return wrap ? HBURST_WRAP4  : HBURST_INCR4;
    endcase
  endfunction

endpackage

// File: rtl/spifi_line_fill_addr_gen.sv
// AHB address counter: loads a start address, steps one word per accepted
// address phase, and optionally wraps inside the line.
module spifi_line_fill_addr_gen
  import spifi_line_fill_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 4,
  parameter bit          WRAP_EN    = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_addr,
  input  logic        advance,
  output logic [31:0] addr
);

  localparam logic [31:0] WRAP_MASK = WRAP_EN ? 32'(LINE_WORDS * 4 - 1) : 32'hFFFF_FFFF;

  logic [31:0] addr_inc;

  assign addr_inc = addr + 32'd4;

  // Address register; the wrap mask keeps the upper bits fixed in wrap mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= 32'd0;
    end else if (load) begin
      addr <= load_addr;
    end else if (advance) begin
      addr <= (addr & ~WRAP_MASK) | (addr_inc & WRAP_MASK);
    end
  end

endmodule

// File: rtl/spifi_line_fill.sv
// Cache line-fill engine: one AHB-Lite read burst per miss, words streamed
// back with their line index. Define SPIFI_LINE_FILL_CWF_EN for critical-word-
// first wrapping bursts; otherwise line-aligned INCR bursts are used.
module spifi_line_fill
  import spifi_line_fill_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 4,
  parameter logic [3:0]  HPROT_VAL  = 4'b0011
) (
  input  logic                          i_hclk,
  input  logic                          i_hreset,
  input  logic                          i_req_valid,
  output logic                          o_req_ready,
  input  logic [31:0]                   i_req_addr,
  output logic                          o_fill_valid,
  output logic [31:0]                   o_fill_word,
  output logic [$clog2(LINE_WORDS)-1:0] o_fill_idx,
  output logic                          o_fill_last,
  output logic                          o_fill_err,
  output logic                          o_hsel,
  output logic                          o_hready_i,
  output logic [31:0]                   o_haddr,
  output logic                          o_hwrite,
  output logic [2:0]                    o_hsize,
  output logic [2:0]                    o_hburst,
  output logic [3:0]                    o_hprot,
  output logic [1:0]                    o_htrans,
  output logic                          o_hmastlock,
  input  logic [31:0]                   i_hrdata,
  input  logic                          i_hready,
  input  logic                          i_hresp
);

  localparam int unsigned IDX_W = $clog2(LINE_WORDS);
  localparam int unsigned CNT_W = IDX_W + 1;
`ifdef SPIFI_LINE_FILL_CWF_EN
  localparam bit          WRAP_EN   = 1'b1;
  localparam logic [31:0] LOAD_MASK = 32'h0000_0003;
`else
  localparam bit          WRAP_EN   = 1'b0;
  localparam logic [31:0] LOAD_MASK = 32'(LINE_WORDS * 4 - 1);
`endif
  localparam logic [2:0]  HBURST    = burst_enc(LINE_WORDS, WRAP_EN);

  state_e             state_q, state_d;
  htrans_e            htrans_q, htrans_d;
  logic               hsel_q, hsel_d;
  logic               dphase_q, dphase_d;
  logic [CNT_W-1:0]   addr_cnt_q, addr_cnt_d;
  logic [CNT_W-1:0]   data_cnt_q, data_cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   start_idx;
  logic               fill_valid_q, fill_valid_d;
  logic               fill_last_q, fill_last_d;
  logic               fill_err_q, fill_err_d;
  logic [31:0]        fill_word_q, fill_word_d;
  logic [IDX_W-1:0]   fill_idx_q, fill_idx_d;
  logic               req_ready_q, req_ready_d;
  logic               ag_load, ag_adv;
  logic [31:0]        req_base;

  assign req_base = i_req_addr & ~LOAD_MASK;
`ifdef SPIFI_LINE_FILL_CWF_EN
  assign start_idx = i_req_addr[IDX_W+1:2];
`else
  assign start_idx = '0;
`endif

  spifi_line_fill_addr_gen #(
    .LINE_WORDS (LINE_WORDS),
    .WRAP_EN    (WRAP_EN)
  ) u_addr_gen (
    .clk       (i_hclk),
    .rst       (i_hreset),
    .load      (ag_load),
    .load_addr (req_base),
    .advance   (ag_adv),
    .addr      (o_haddr)
  );

  // State and output registers.
  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      state_q      <= ST_IDLE;
      htrans_q     <= HTRANS_IDLE;
      hsel_q       <= 1'b0;
      dphase_q     <= 1'b0;
      addr_cnt_q   <= '0;
      data_cnt_q   <= '0;
      idx_q        <= '0;
      fill_valid_q <= 1'b0;
      fill_last_q  <= 1'b0;
      fill_err_q   <= 1'b0;
      fill_word_q  <= 32'd0;
      fill_idx_q   <= '0;
      req_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      htrans_q     <= htrans_d;
      hsel_q       <= hsel_d;
      dphase_q     <= dphase_d;
      addr_cnt_q   <= addr_cnt_d;
      data_cnt_q   <= data_cnt_d;
      idx_q        <= idx_d;
      fill_valid_q <= fill_valid_d;
      fill_last_q  <= fill_last_d;
      fill_err_q   <= fill_err_d;
      fill_word_q  <= fill_word_d;
      fill_idx_q   <= fill_idx_d;
      req_ready_q  <= req_ready_d;
    end
  end

  // Next state: address pipeline, data capture and error abort.
  always_comb begin
    state_d      = state_q;
    htrans_d     = htrans_q;
    hsel_d       = hsel_q;
    dphase_d     = dphase_q;
    addr_cnt_d   = addr_cnt_q;
    data_cnt_d   = data_cnt_q;
    idx_d        = idx_q;
    fill_valid_d = 1'b0;
    fill_last_d  = 1'b0;
    fill_err_d   = 1'b0;
    fill_word_d  = fill_word_q;
    fill_idx_d   = fill_idx_q;
    req_ready_d  = req_ready_q;
    ag_load      = 1'b0;
    ag_adv       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_req_valid && req_ready_q) begin
          state_d     = ST_ADDR;
          htrans_d    = HTRANS_NONSEQ;
          hsel_d      = 1'b1;
          dphase_d    = 1'b0;
          addr_cnt_d  = CNT_W'(LINE_WORDS);
          data_cnt_d  = CNT_W'(LINE_WORDS);
          idx_d       = start_idx;
          req_ready_d = 1'b0;
          ag_load     = 1'b1;
        end
      end

      ST_ADDR, ST_DATA: begin
        if (dphase_q && i_hresp) begin
          // Two-cycle ERROR: cancel on the first cycle, report on the second.
          htrans_d = HTRANS_IDLE;
          if (i_hready) begin
            state_d     = ST_IDLE;
            fill_last_d = 1'b1;
            fill_err_d  = 1'b1;
            req_ready_d = 1'b1;
            hsel_d      = 1'b0;
            dphase_d    = 1'b0;
          end else begin
            state_d = ST_ERR;
          end
        end else begin
          if (dphase_q && i_hready) begin
            fill_valid_d = 1'b1;
            fill_word_d  = i_hrdata;
            fill_idx_d   = idx_q;
            idx_d        = idx_q + IDX_W'(1);
            data_cnt_d   = data_cnt_q - CNT_W'(1);
            if (data_cnt_q == CNT_W'(1)) begin
              state_d     = ST_IDLE;
              fill_last_d = 1'b1;
              req_ready_d = 1'b1;
              hsel_d      = 1'b0;
              dphase_d    = 1'b0;
            end
          end
          if (state_q == ST_ADDR && i_hready) begin
            dphase_d   = 1'b1;
            addr_cnt_d = addr_cnt_q - CNT_W'(1);
            if (addr_cnt_q == CNT_W'(1)) begin
              htrans_d = HTRANS_IDLE;
              state_d  = ST_DATA;
            end else begin
              htrans_d = HTRANS_SEQ;
              ag_adv   = 1'b1;
            end
          end
        end
      end

      ST_ERR: begin
        if (i_hready) begin
          state_d     = ST_IDLE;
          fill_last_d = 1'b1;
          fill_err_d  = 1'b1;
          req_ready_d = 1'b1;
          hsel_d      = 1'b0;
          dphase_d    = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign o_req_ready  = req_ready_q;
  assign o_fill_valid = fill_valid_q;
  assign o_fill_word  = fill_word_q;
  assign o_fill_idx   = fill_idx_q;
  assign o_fill_last  = fill_last_q;
  assign o_fill_err   = fill_err_q;
  assign o_hsel       = hsel_q;
  assign o_hready_i   = i_hready;
  assign o_hwrite     = 1'b0;
  assign o_hsize      = 3'b010;
  assign o_hburst     = HBURST;
  assign o_hprot      = HPROT_VAL;
  assign o_htrans     = htrans_q;
  assign o_hmastlock  = 1'b0;

endmodule

// File: tb/tb_spifi_line_fill.sv
// Bench for spifi_line_fill (LINE_WORDS=4). Honours SPIFI_LINE_FILL_CWF_EN.
// A small AHB slave model answers the bursts; address and fill scoreboards
// are filled when a request is issued and drained by independent monitors.
module tb_spifi_line_fill;

  localparam int LW = 4;
`ifdef SPIFI_LINE_FILL_CWF_EN
  localparam bit         CWF       = 1'b1;
  localparam logic [2:0] EXP_BURST = 3'b010;
`else
  localparam bit         CWF       = 1'b0;
  localparam logic [2:0] EXP_BURST = 3'b011;
`endif

  logic        clk = 1'b0;
  logic        hreset = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic        o_req_ready, o_fill_valid, o_fill_last, o_fill_err;
  logic [31:0] o_fill_word, o_haddr;
  logic [1:0]  o_fill_idx, o_htrans;
  logic        o_hsel, o_hready_i, o_hwrite, o_hmastlock;
  logic [2:0]  o_hsize, o_hburst;
  logic [3:0]  o_hprot;
  logic [31:0] hrdata;
  logic        hready, hresp;

  always #5 clk = ~clk;

  spifi_line_fill #(.LINE_WORDS(4), .HPROT_VAL(4'b0011)) dut (
    .i_hclk(clk), .i_hreset(hreset),
    .i_req_valid(req_valid), .o_req_ready(o_req_ready), .i_req_addr(req_addr),
    .o_fill_valid(o_fill_valid), .o_fill_word(o_fill_word), .o_fill_idx(o_fill_idx),
    .o_fill_last(o_fill_last), .o_fill_err(o_fill_err),
    .o_hsel(o_hsel), .o_hready_i(o_hready_i), .o_haddr(o_haddr), .o_hwrite(o_hwrite),
    .o_hsize(o_hsize), .o_hburst(o_hburst), .o_hprot(o_hprot), .o_htrans(o_htrans),
    .o_hmastlock(o_hmastlock), .i_hrdata(hrdata), .i_hready(hready), .i_hresp(hresp)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lasts_seen = 0;
  int lasts_exp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] addr; logic [1:0] trans; int cyc; } addr_exp_t;
  typedef struct { logic [31:0] word; logic [1:0] idx; logic valid; logic last; logic err; int cyc; } fill_exp_t;
  addr_exp_t addr_q[$];
  fill_exp_t fill_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[15:0]};
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] req, input int k);
    logic [3:0] off;
    off = (CWF ? (req[3:0] & 4'hC) : 4'h0) + 4'(k * 4);
    return (req & 32'hFFFF_FFF0) | {28'd0, off};
  endfunction

  function automatic logic [1:0] beat_idx(input logic [31:0] req, input int k);
    logic [1:0] s;
    s = CWF ? req[3:2] : 2'd0;
    return s + 2'(k);
  endfunction

  // Slave model: wait states on data phase of beat s_wb, two-cycle ERROR on beat s_eb.
  int s_wb = -1, s_wn = 0, s_eb = -1;
  logic        dp_valid = 1'b0;
  logic [31:0] dp_addr = 32'd0;
  int          dp_beat = 0, dp_cyc = 0, beat_ctr = 0;

  always @(posedge clk) begin
    if (hreset) begin
      dp_valid <= 1'b0;
      dp_cyc   <= 0;
      beat_ctr <= 0;
    end else if (hready) begin
      dp_cyc <= 0;
      if (o_hsel && o_htrans[1]) begin
        dp_valid <= 1'b1;
        dp_addr  <= o_haddr;
        dp_beat  <= (o_htrans == 2'b10) ? 0 : beat_ctr;
        beat_ctr <= (o_htrans == 2'b10) ? 1 : beat_ctr + 1;
      end else begin
        dp_valid <= 1'b0;
      end
    end else begin
      dp_cyc <= dp_cyc + 1;
    end
  end

  always_comb begin
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = 32'd0;
    if (dp_valid) begin
      if (dp_beat == s_eb) begin
        hresp  = 1'b1;
        hready = (dp_cyc != 0);
      end else if (dp_beat == s_wb && dp_cyc < s_wn) begin
        hready = 1'b0;
      end else begin
        hrdata = mem_word(dp_addr);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Address monitor: every accepted address phase must match the scoreboard.
  always @(negedge clk) begin : addr_mon
    addr_exp_t e;
    if (o_htrans != 2'b00 && hready === 1'b1) begin
      checks++;
      if (addr_q.size() == 0) begin
        errors++;
        $display("FAIL addr: unexpected trans %0d addr 0x%08h at cyc %0d", o_htrans, o_haddr, cyc);
      end else begin
        e = addr_q.pop_front();
        if (o_haddr !== e.addr || o_htrans !== e.trans || o_hsel !== 1'b1 || cyc != e.cyc) begin
          errors++;
          $display("FAIL addr: got 0x%08h trans %0d hsel %0b cyc %0d required 0x%08h trans %0d hsel 1 cyc %0d",
                   o_haddr, o_htrans, o_hsel, cyc, e.addr, e.trans, e.cyc);
        end
      end
    end
  end

  // Fill monitor: every data or error pulse must match the scoreboard.
  always @(negedge clk) begin : fill_mon
    fill_exp_t e;
    if (o_fill_valid === 1'b1 || o_fill_last === 1'b1) begin
      checks++;
      if (o_fill_last === 1'b1) lasts_seen++;
      if (fill_q.size() == 0) begin
        errors++;
        $display("FAIL fill: unexpected pulse idx %0d last %0b at cyc %0d", o_fill_idx, o_fill_last, cyc);
      end else begin
        e = fill_q.pop_front();
        if (o_fill_valid !== e.valid || o_fill_last !== e.last || o_fill_err !== e.err ||
            o_req_ready !== e.last || cyc != e.cyc ||
            (e.valid && (o_fill_word !== e.word || o_fill_idx !== e.idx))) begin
          errors++;
          $display("FAIL fill: got v%0b l%0b e%0b rdy%0b idx %0d word 0x%08h cyc %0d required v%0b l%0b e%0b rdy%0b idx %0d word 0x%08h cyc %0d",
                   o_fill_valid, o_fill_last, o_fill_err, o_req_ready, o_fill_idx, o_fill_word, cyc,
                   e.valid, e.last, e.err, e.last, e.idx, e.word, e.cyc);
        end
      end
    end
  end

  // Expected bus and fill timeline for a request presented in cycle c.
  task automatic expect_line(input logic [31:0] req, input int c, input int wb, input int wn, input int eb);
    addr_exp_t ea;
    fill_exp_t ef;
    int a, d;
    a = c + 1;
    for (int k = 0; k < LW; k++) begin
      ea.addr  = beat_addr(req, k);
      ea.trans = (k == 0) ? 2'b10 : 2'b11;
      ea.cyc   = a;
      addr_q.push_back(ea);
      if (k == eb) begin
        ef.word = 32'd0; ef.idx = 2'd0; ef.valid = 1'b0; ef.last = 1'b1; ef.err = 1'b1; ef.cyc = a + 3;
        fill_q.push_back(ef);
        lasts_exp++;
        return;
      end
      d = a + 1 + ((k == wb) ? wn : 0);
      ef.word = mem_word(beat_addr(req, k)); ef.idx = beat_idx(req, k);
      ef.valid = 1'b1; ef.last = (k == LW - 1); ef.err = 1'b0; ef.cyc = d + 1;
      fill_q.push_back(ef);
      if (k == LW - 1) lasts_exp++;
      a = d;
    end
  endtask

  task automatic set_slave(input int wb, input int wn, input int eb);
    s_wb = wb; s_wn = wn; s_eb = eb;
  endtask

  // Present one request for a single cycle; returns the request cycle.
  task automatic issue(input logic [31:0] a, input int wb, input int wn, input int eb, output int c);
    set_slave(wb, wn, eb);
    c = cyc;
    expect_line(a, c, wb, wn, eb);
    req_addr  = a;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("first_trans", 32'(o_htrans), 32'h2);
    chk("first_addr", o_haddr, beat_addr(a, 0));
    chk("hburst", 32'(o_hburst), 32'(EXP_BURST));
  endtask

  task automatic wait_last(input int budget);
    int n;
    n = 0;
    while (lasts_seen < lasts_exp && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("last_timeout", 32'(lasts_seen), 32'(lasts_exp));
    @(negedge clk);
  endtask

  initial begin
    int c;
    int l0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(o_req_ready), 32'd1);
    chk("rst_htrans", 32'(o_htrans), 32'd0);
    chk("rst_hsel", 32'(o_hsel), 32'd0);
    chk("rst_haddr", o_haddr, 32'd0);
    chk("rst_fill_valid", 32'(o_fill_valid), 32'd0);
    chk("rst_fill_last", 32'(o_fill_last), 32'd0);
    chk("rst_fill_err", 32'(o_fill_err), 32'd0);
    chk("rst_fill_word", o_fill_word, 32'd0);
    chk("rst_fill_idx", 32'(o_fill_idx), 32'd0);
    chk("const_ctrl", {23'd0, o_hwrite, o_hmastlock, o_hsize, o_hprot}, {23'd0, 1'b0, 1'b0, 3'b010, 4'b0011});
    hreset = 1'b0;
    @(negedge clk);

    // Zero-wait line from 0x1234.
    issue(32'h0000_1234, -1, 0, -1, c);
    chk("hready_pass_hi", 32'(o_hready_i), 32'd1);
    wait_last(20);

    // Two wait states while the beat-1 address is on the bus.
    issue(32'h0000_1234, 0, 2, -1, c);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("wait_hold_addr", o_haddr, beat_addr(32'h0000_1234, 1));
      chk("wait_hold_trans", 32'(o_htrans), 32'h3);
      chk("hready_pass_lo", 32'(o_hready_i), 32'd0);
    end
    @(negedge clk);
    chk("wait_hold_addr3", o_haddr, beat_addr(32'h0000_1234, 1));
    wait_last(30);

    // Slave ERROR on beat 2.
    issue(32'h0000_2000, -1, 0, 2, c);
    repeat (4) @(negedge clk);
    chk("err_cancel_idle", 32'(o_htrans), 32'd0);
    wait_last(20);

    // Back-to-back requests held by the requester.
    set_slave(-1, 0, -1);
    c = cyc;
    expect_line(32'h0000_0100, c, -1, 0, -1);
    expect_line(32'h0000_0200, c + 6, -1, 0, -1);
    req_addr  = 32'h0000_0100;
    req_valid = 1'b1;
    @(negedge clk);
    req_addr = 32'h0000_0200;
    repeat (6) @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_nonseq", 32'(o_htrans), 32'h2);
    chk("b2b_addr", o_haddr, 32'h0000_0200);
    wait_last(30);

    // Reset mid-burst: bus goes idle and no completion is reported.
    set_slave(-1, 0, -1);
    c = cyc;
    begin
      addr_exp_t ea;
      ea.addr = beat_addr(32'h0000_3000, 0); ea.trans = 2'b10; ea.cyc = c + 1; addr_q.push_back(ea);
      ea.addr = beat_addr(32'h0000_3000, 1); ea.trans = 2'b11; ea.cyc = c + 2; addr_q.push_back(ea);
    end
    req_addr  = 32'h0000_3000;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    hreset = 1'b1;
    @(negedge clk);
    chk("mid_rst_htrans", 32'(o_htrans), 32'd0);
    chk("mid_rst_ready", 32'(o_req_ready), 32'd1);
    chk("mid_rst_fill_valid", 32'(o_fill_valid), 32'd0);
    chk("mid_rst_fill_last", 32'(o_fill_last), 32'd0);
    hreset = 1'b0;
    l0 = lasts_seen;
    repeat (8) @(negedge clk);
    chk("mid_rst_no_last", 32'(lasts_seen), 32'(l0));

    // Request 0x1238 (critical-word-first start at word 2 when enabled).
    issue(32'h0000_1238, -1, 0, -1, c);
    wait_last(20);

    repeat (3) @(negedge clk);
    chk("addr_q_drained", 32'(addr_q.size()), 32'd0);
    chk("fill_q_drained", 32'(fill_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1);
  end

endmodule
